// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: ID/EX register-match inputs, memory busy and pipeline-control outputs.
// master drives the hazard inputs; slave is the hazard unit.
interface hazard_unit_mc_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [ADDR_W-1:0] id_rs_i;
  logic [ADDR_W-1:0] id_rt_i;
  logic              id_uses_rt_i;
  logic              id_branch_i;
  logic              branch_taken_i;
  logic [ADDR_W-1:0] ex_rd_i;
  logic              ex_memread_i;
  logic              ex_regwrite_i;
  logic              dmem_busy_i;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic              bubble_o;
  logic              if_id_flush_o;
  logic              freeze_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, id_branch_i, branch_taken_i,
    output ex_rd_i, ex_memread_i, ex_regwrite_i, dmem_busy_i,
    input  pc_write_o, if_id_write_o, bubble_o, if_id_flush_o, freeze_o, stall_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, id_branch_i, branch_taken_i,
    input  ex_rd_i, ex_memread_i, ex_regwrite_i, dmem_busy_i,
    output pc_write_o, if_id_write_o, bubble_o, if_id_flush_o, freeze_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard unit: load-use / ID-branch stalls held by a down-counter, dmem freeze, flush.
// Optional stall statistics counter enabled by defining HD_STATS_EN.
module hazard_unit_mc #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned BR_STALL   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  hazard_unit_mc_if.slave hz
);

  localparam logic [2:0] LoadN = 3'(LOAD_STALL);
  localparam logic [2:0] BrN   = 3'(BR_STALL);

  typedef enum logic {StIdle, StHold} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_stall;
  logic [ADDR_W-1:0] ex_rd;
  logic              rs_hit, rt_hit, load_haz, br_haz;
  logic              pc_write, if_id_write, bubble, flush, freeze;

  assign ex_rd    = hz.ex_rd_i;
  // $zero is never a real producer, so it never matches
  assign rs_hit   = (ex_rd != '0) && (hz.id_rs_i == ex_rd);
  assign rt_hit   = (ex_rd != '0) && hz.id_uses_rt_i && (hz.id_rt_i == ex_rd);
  assign load_haz = hz.ex_memread_i && (rs_hit || rt_hit);
  assign br_haz   = hz.id_branch_i && hz.ex_regwrite_i && !hz.ex_memread_i && (rs_hit || rt_hit);
  assign n_stall  = load_haz ? LoadN : BrN;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;
    freeze      = 1'b0;
    if (rst_i) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (hz.dmem_busy_i) begin
      freeze      = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (state_q == StHold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
      cnt_d       = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = StIdle;
    end else if (load_haz || br_haz) begin
      // First bubble is issued this cycle; HOLD covers only the remainder
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
      if (n_stall > 3'd1) begin
        state_d = StHold;
        cnt_d   = n_stall - 3'd1;
      end
    end else if (hz.branch_taken_i) begin
      flush = 1'b1;
    end
  end

  assign hz.pc_write_o    = pc_write;
  assign hz.if_id_write_o = if_id_write;
  assign hz.bubble_o      = bubble;
  assign hz.if_id_flush_o = flush;
  assign hz.freeze_o      = freeze;

`ifdef HD_STATS_EN
  logic [CNT_W-1:0] stat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= '0;
    end else if (bubble && !freeze && (stat_q != '1)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign hz.stall_cnt_o = stat_q;
`else
  assign hz.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (LOAD_STALL=3/BR_STALL=2 and 1/1) on shared inputs,
// directed scenario tasks plus random stimulus against a remaining-stall-count model.
module tb_hazard_unit_mc;

`ifdef HD_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif
  localparam int StatMax = 65535;
  localparam int LoadA = 3, BrA = 2, LoadB = 1, BrB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.ADDR_W(5), .CNT_W(16)) bus ();
  hazard_unit_mc_if #(.ADDR_W(5), .CNT_W(16)) bus1 ();

  assign bus1.id_rs_i        = bus.id_rs_i;
  assign bus1.id_rt_i        = bus.id_rt_i;
  assign bus1.id_uses_rt_i   = bus.id_uses_rt_i;
  assign bus1.id_branch_i    = bus.id_branch_i;
  assign bus1.branch_taken_i = bus.branch_taken_i;
  assign bus1.ex_rd_i        = bus.ex_rd_i;
  assign bus1.ex_memread_i   = bus.ex_memread_i;
  assign bus1.ex_regwrite_i  = bus.ex_regwrite_i;
  assign bus1.dmem_busy_i    = bus.dmem_busy_i;

  hazard_unit_mc #(.ADDR_W(5), .LOAD_STALL(LoadA), .BR_STALL(BrA), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .hz(bus.slave)
  );
  hazard_unit_mc #(.ADDR_W(5), .LOAD_STALL(LoadB), .BR_STALL(BrB), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .hz(bus1.slave)
  );

  // {pc_write, if_id_write, bubble, flush, freeze}
  logic [4:0] a_out, b_out;
  assign a_out = {bus.pc_write_o, bus.if_id_write_o, bus.bubble_o, bus.if_id_flush_o,
                  bus.freeze_o};
  assign b_out = {bus1.pc_write_o, bus1.if_id_write_o, bus1.bubble_o, bus1.if_id_flush_o,
                  bus1.freeze_o};

  localparam logic [4:0] OutZero = 5'b00000, OutNorm = 5'b11000, OutStall = 5'b00100;
  localparam logic [4:0] OutFlush = 5'b11010, OutFreeze = 5'b00001;

  // ---------------- reference model: remaining stall cycles as an integer ----------------
  int m_left_a = 0, m_left_b = 0, m_stat_a = 0, m_stat_b = 0;

  function automatic bit reg_match();
    return (bus.ex_rd_i != 0) &&
           ((bus.id_rs_i == bus.ex_rd_i) || (bus.id_uses_rt_i && bus.id_rt_i == bus.ex_rd_i));
  endfunction

  function automatic bit is_load();
    return bus.ex_memread_i && reg_match();
  endfunction

  function automatic bit is_br();
    return bus.id_branch_i && bus.ex_regwrite_i && !bus.ex_memread_i && reg_match();
  endfunction

  function automatic logic [4:0] model_out(input int left);
    if (rst) return OutZero;
    if (bus.dmem_busy_i) return OutFreeze;
    if (left > 0 || is_load() || is_br()) return OutStall;
    if (bus.branch_taken_i) return OutFlush;
    return OutNorm;
  endfunction

  function automatic int next_left(input int left, input int nl, input int nb);
    if (bus.dmem_busy_i) return left;
    if (left > 0) return left - 1;
    if (is_load()) return nl - 1;
    if (is_br()) return nb - 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left_a <= 0;
      m_left_b <= 0;
      m_stat_a <= 0;
      m_stat_b <= 0;
    end else begin
      m_left_a <= next_left(m_left_a, LoadA, BrA);
      m_left_b <= next_left(m_left_b, LoadB, BrB);
      if (model_out(m_left_a) == OutStall && m_stat_a < StatMax) m_stat_a <= m_stat_a + 1;
      if (model_out(m_left_b) == OutStall && m_stat_b < StatMax) m_stat_b <= m_stat_b + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.id_rs_i        = '0;
    bus.id_rt_i        = '0;
    bus.id_uses_rt_i   = 1'b0;
    bus.id_branch_i    = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.ex_rd_i        = '0;
    bus.ex_memread_i   = 1'b0;
    bus.ex_regwrite_i  = 1'b0;
    bus.dmem_busy_i    = 1'b0;
  endtask

  task automatic settle();
    idle_inputs();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic load_hazard();
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i      = 5'd8;
    bus.id_rs_i      = 5'd8;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_out !== OutZero) begin
      n_err++; $display("FAIL reset_outs_a: got %b expected %b", a_out, OutZero);
    end
    n_cmp++;
    if (b_out !== OutZero) begin
      n_err++; $display("FAIL reset_outs_b: got %b expected %b", b_out, OutZero);
    end
    n_cmp++;
    if (bus.stall_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL reset_stat: got %0d expected 0", bus.stall_cnt_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_out !== OutNorm) begin
      n_err++; $display("FAIL post_reset_norm: got %b expected %b", a_out, OutNorm);
    end
  endtask

  task automatic test_load_use();
    settle();
    load_hazard();
    @(negedge clk);
    n_cmp++;
    if (b_out !== OutStall) begin
      n_err++; $display("FAIL load_use_stall: got %b expected %b", b_out, OutStall);
    end
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (b_out !== OutNorm) begin
      n_err++; $display("FAIL load_use_release: got %b expected %b", b_out, OutNorm);
    end
  endtask

  task automatic test_multi_load();
    settle();
    load_hazard();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out !== ((i < 3) ? OutStall : OutNorm)) begin
        n_err++; $display("FAIL multi_load cyc%0d: got %b expected %b", i, a_out,
                          (i < 3) ? OutStall : OutNorm);
      end
      @(posedge clk);
      #1 idle_inputs();
    end
  endtask

  task automatic test_zero_filter();
    settle();
    bus.ex_memread_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (a_out !== OutNorm || b_out !== OutNorm) begin
      n_err++; $display("FAIL zero_reg: got %b/%b expected %b", a_out, b_out, OutNorm);
    end
    @(posedge clk);
    #1;
    bus.ex_rd_i = 5'd9;
    bus.id_rt_i = 5'd9;
    bus.id_rs_i = 5'd3;
    @(negedge clk);
    n_cmp++;
    if (a_out !== OutNorm || b_out !== OutNorm) begin
      n_err++; $display("FAIL rt_unused: got %b/%b expected %b", a_out, b_out, OutNorm);
    end
    @(posedge clk);
    #1 bus.id_uses_rt_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b_out !== OutStall) begin
      n_err++; $display("FAIL rt_used: got %b expected %b", b_out, OutStall);
    end
  endtask

  task automatic test_branch();
    logic [4:0] exp [4];
    exp = '{OutStall, OutStall, OutFlush, OutNorm};
    settle();
    bus.id_branch_i    = 1'b1;
    bus.ex_regwrite_i  = 1'b1;
    bus.ex_rd_i        = 5'd4;
    bus.id_rt_i        = 5'd4;
    bus.id_uses_rt_i   = 1'b1;
    bus.branch_taken_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out !== exp[i]) begin
        n_err++; $display("FAIL branch cyc%0d: got %b expected %b", i, a_out, exp[i]);
      end
      @(posedge clk);
      #1;
      if (i == 1) bus.ex_regwrite_i = 1'b0;
      if (i == 2) bus.branch_taken_i = 1'b0;
    end
  endtask

  task automatic test_freeze_hold();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    load_hazard();
    @(negedge clk);
    n_cmp++;
    if (a_out !== OutStall) begin
      n_err++; $display("FAIL freeze_first: got %b expected %b", a_out, OutStall);
    end
    @(posedge clk);
    #1 idle_inputs();
    bus.dmem_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out !== OutFreeze) begin
        n_err++; $display("FAIL freeze cyc%0d: got %b expected %b", i, a_out, OutFreeze);
      end
      @(posedge clk);
      #1;
    end
    bus.dmem_busy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out !== ((i < 2) ? OutStall : OutNorm)) begin
        n_err++; $display("FAIL freeze_resume cyc%0d: got %b expected %b", i, a_out,
                          (i < 2) ? OutStall : OutNorm);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bus.stall_cnt_o !== (StatsEn ? 16'd3 : 16'd0)) begin
      n_err++; $display("FAIL freeze_stat: got %0d expected %0d", bus.stall_cnt_o,
                        StatsEn ? 3 : 0);
    end
  endtask

  task automatic test_async_reset();
    settle();
    load_hazard();
    @(posedge clk);
    #1 idle_inputs();
    #1;
    n_cmp++;
    if (a_out !== OutStall) begin
      n_err++; $display("FAIL areset_pre: got %b expected %b", a_out, OutStall);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (a_out !== OutZero || bus.stall_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL areset_zero: got %b cnt %0d expected %b cnt 0", a_out,
                        bus.stall_cnt_o, OutZero);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (a_out !== OutNorm) begin
      n_err++; $display("FAIL areset_release: got %b expected %b", a_out, OutNorm);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_out !== OutNorm || bus.stall_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL areset_dropped: got %b cnt %0d expected %b cnt 0", a_out,
                        bus.stall_cnt_o, OutNorm);
    end
  endtask

  task automatic test_back_to_back();
    settle();
    load_hazard();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out !== OutStall || b_out !== OutStall) begin
        n_err++; $display("FAIL b2b cyc%0d: got %b/%b expected %b", i, a_out, b_out, OutStall);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (b_out !== OutNorm) begin
      n_err++; $display("FAIL b2b_release: got %b expected %b", b_out, OutNorm);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bus.id_rs_i        = 5'($urandom_range(0, 3));
      bus.id_rt_i        = 5'($urandom_range(0, 3));
      bus.ex_rd_i        = 5'($urandom_range(0, 3));
      bus.id_uses_rt_i   = 1'($urandom_range(0, 1));
      bus.id_branch_i    = 1'($urandom_range(0, 1));
      bus.branch_taken_i = 1'($urandom_range(0, 1));
      bus.ex_memread_i   = ($urandom_range(0, 2) == 0);
      bus.ex_regwrite_i  = 1'($urandom_range(0, 1));
      bus.dmem_busy_i    = ($urandom_range(0, 7) == 0);
      rst                = ($urandom_range(0, 79) == 0);
      @(negedge clk);
      n_cmp++;
      if (a_out !== model_out(m_left_a)) begin
        n_err++; $display("FAIL rand_a cyc%0d: got %b expected %b", i, a_out,
                          model_out(m_left_a));
      end
      n_cmp++;
      if (b_out !== model_out(m_left_b)) begin
        n_err++; $display("FAIL rand_b cyc%0d: got %b expected %b", i, b_out,
                          model_out(m_left_b));
      end
      n_cmp++;
      if (32'(bus.stall_cnt_o) !== (StatsEn ? m_stat_a : 0) ||
          32'(bus1.stall_cnt_o) !== (StatsEn ? m_stat_b : 0)) begin
        n_err++; $display("FAIL rand_stat cyc%0d: got %0d/%0d expected %0d/%0d", i,
                          bus.stall_cnt_o, bus1.stall_cnt_o, StatsEn ? m_stat_a : 0,
                          StatsEn ? m_stat_b : 0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_multi_load();
    test_zero_filter();
    test_branch();
    test_freeze_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the single-cycle load-use detector in the 5-stage MIPS pipeline; sits in ID and drives PC write enable, IF/ID write enable, IF/ID flush and the ID/EX control-bubble mux.
- Adds multi-cycle load-use stalls, ID-stage branch operand hazards, data-memory busy freeze and taken-branch flush.
- Sequential: a hold FSM with a down-counter sustains stalls across cycles.

Parameters:
- ADDR_W, 5, register address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard (legal 1..7).
- BR_STALL, 1, bubble cycles when an ID-resolved branch needs an operand still in EX (legal 1..7).
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- id_rs_i  in  ADDR_W  rs of instruction in ID.
- id_rt_i  in  ADDR_W  rt of instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- id_branch_i  in  1  ID instruction is a branch compared in ID.
- branch_taken_i  in  1  branch in ID resolved taken this cycle.
- ex_rd_i  in  ADDR_W  destination register of EX instruction.
- ex_memread_i  in  1  EX instruction is a load.
- ex_regwrite_i  in  1  EX instruction writes a register.
- dmem_busy_i  in  1  data memory has not completed; whole pipe freezes.
- pc_write_o  out  1  PC write enable.
- if_id_write_o  out  1  IF/ID write enable.
- bubble_o  out  1  select zero controls into ID/EX.
- if_id_flush_o  out  1  clear IF/ID.
- freeze_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  bubble-cycle count; see Optional Feature.

Behaviour:
- Match (combinational): rs_hit = (id_rs_i == ex_rd_i); rt_hit = id_uses_rt_i & (id_rt_i == ex_rd_i). Register 0 never matches (ex_rd_i == 0 means no hit).
- load_haz = ex_memread_i & (rs_hit | rt_hit).
- br_haz = id_branch_i & ex_regwrite_i & ~ex_memread_i & (rs_hit | rt_hit). A load feeding a branch counts as load_haz.
- FSM states: IDLE, HOLD. Counter cnt is 3 bits.
- Priority, highest first: rst_i > dmem_busy_i > HOLD > load_haz/br_haz > branch_taken_i > normal.
- During rst_i and until the first edge after release:
  - state = IDLE, cnt = 0, stall_cnt_o = 0.
  - pc_write_o = 0, if_id_write_o = 0, bubble_o = 0, if_id_flush_o = 0, freeze_o = 0.
  - Outputs go to normal values combinationally once rst_i falls.
- dmem_busy_i = 1, any state:
  - freeze_o = 1, pc_write_o = 0, if_id_write_o = 0, bubble_o = 0, if_id_flush_o = 0.
  - state and cnt hold; no hazard is evaluated.
- IDLE with load_haz or br_haz:
  - pc_write_o = 0, if_id_write_o = 0, bubble_o = 1 in the same cycle (zero latency, as in the single-cycle detector).
  - N = LOAD_STALL if load_haz, else BR_STALL.
  - If N > 1: next state HOLD with cnt = N-1. Otherwise stay in IDLE.
  - branch_taken_i is ignored (its operands are stale).
- HOLD:
  - Outputs as in a stall cycle, regardless of hazard inputs.
  - cnt decrements each unfrozen cycle; when cnt == 1, next state is IDLE.
  - Hazards are re-evaluated in IDLE on the following cycle, which allows back-to-back stalls.
- IDLE, no hazard, branch_taken_i = 1: if_id_flush_o = 1, pc_write_o = 1, if_id_write_o = 1, bubble_o = 0.
- Normal: pc_write_o = 1, if_id_write_o = 1, bubble_o = 0, if_id_flush_o = 0, freeze_o = 0.
- Reset asserted mid-HOLD: returns to IDLE immediately (asynchronous); the remaining stall cycles are dropped.

Optional Feature:
- Macro HD_STATS_EN.
- Defined: stall_cnt_o increments by 1 on each clock edge where bubble_o = 1 and freeze_o = 0; it saturates at all-ones and clears only on reset.
- Undefined: no counter logic; stall_cnt_o is tied to 0.

Test Plan:
- Load-use: LOAD_STALL=1, ex_memread_i=1, ex_rd_i=8, id_rs_i=8 for one cycle -> one cycle with pc_write_o=0, if_id_write_o=0, bubble_o=1; next cycle normal.
- Multi-cycle load: LOAD_STALL=3, same hazard, inputs then cleared -> bubble_o=1 for exactly 3 cycles, then pc_write_o=1.
- $zero and rt filter:
  - ex_rd_i=0, id_rs_i=0, ex_memread_i=1 -> no stall.
  - id_rt_i=ex_rd_i=9 with id_uses_rt_i=0 -> no stall.
- Branch hazard: BR_STALL=2, id_branch_i=1, ex_regwrite_i=1, ex_memread_i=0, ex_rd_i=id_rt_i=4, id_uses_rt_i=1, branch_taken_i=1 -> 2 bubble cycles with if_id_flush_o=0; after the hazard clears, branch_taken_i=1 -> if_id_flush_o=1 for one cycle.
- Freeze in HOLD: LOAD_STALL=3, dmem_busy_i=1 for 4 cycles during the 2nd stall cycle -> freeze_o=1 and bubble_o=0 for 4 cycles; then 2 remaining bubble cycles; with HD_STATS_EN, stall_cnt_o=3 at the end.
- Async reset in HOLD: assert rst_i between edges in the 2nd stall cycle -> all outputs 0 at once; after release, normal outputs, stall_cnt_o=0.
